pkt_reader: RTL and testbench

Per-output-port read engine for the shared packet SRAM, the read-side counterpart of the write path (fifo, write_arbiter, datasg). It accepts one packet descriptor at a time (start address, length, priority) from the cache manager. It issues sequential SRAM read-port accesses, absorbs the SRAM read latency in a small credit-controlled buffer, and emits the packet on the port's rd_sop/rd_vld/rd_eop/rd_data interface with downstream backpressure. It pulses `done` when the last word leaves, so the cache manager can release the addresses.

---
 rtl/sw_pkg.sv | 25 ++
 rtl/pkt_reader_if.sv | 59 +++++
 rtl/pkt_rd_buf.sv | 68 ++++++
 rtl/pkt_reader.sv | 205 ++++++++++++++++++++
 tb/tb_pkt_reader.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared switch constants (bus widths used by datasg,
//                cache_manager and pkt_reader) and the packet-reader
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_pkg;

    localparam int SW_DATA_WIDTH = 64;
    localparam int SW_ADDR_WIDTH = 17;
    localparam int SW_LEN_WIDTH  = 8;
    localparam int SW_PRIO_WIDTH = 3;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/pkt_reader_if.sv
// ============================================================================
//  Module      : pkt_reader_if
//  Description : Descriptor, SRAM read-port and packet output signals of the
//                per-port read engine. The len_err signal only exists when
//                PKT_READER_LEN_CHK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pkt_reader_if import sw_pkg::*; #(
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int ADDR_WIDTH = SW_ADDR_WIDTH,
    parameter int LEN_WIDTH  = SW_LEN_WIDTH,
    parameter int PRIO_WIDTH = SW_PRIO_WIDTH
) ();

    logic                  desc_vld;
    logic                  desc_rdy;
    logic [ADDR_WIDTH-1:0] desc_addr;
    logic [LEN_WIDTH-1:0]  desc_len;
    logic [PRIO_WIDTH-1:0] desc_prio;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  out_ready;
    logic                  rd_vld;
    logic                  rd_sop;
    logic                  rd_eop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic [PRIO_WIDTH-1:0] done_prio;
    logic                  busy;
`ifdef PKT_READER_LEN_CHK_EN
    logic                  len_err;
`endif

    // Read engine side
    modport master (
        input  desc_vld, desc_addr, desc_len, desc_prio, doutb, out_ready,
        output desc_rdy, enb, addrb, rd_vld, rd_sop, rd_eop, rd_data,
        output done, done_prio, busy
`ifdef PKT_READER_LEN_CHK_EN
        , output len_err
`endif
    );

    // Cache manager / SRAM / downstream side
    modport slave (
        output desc_vld, desc_addr, desc_len, desc_prio, doutb, out_ready,
        input  desc_rdy, enb, addrb, rd_vld, rd_sop, rd_eop, rd_data,
        input  done, done_prio, busy
`ifdef PKT_READER_LEN_CHK_EN
        , input len_err
`endif
    );

endinterface

`default_nettype wire

// File: rtl/pkt_rd_buf.sv
// ============================================================================
//  Module      : pkt_rd_buf
//  Description : Small synchronous FIFO holding SRAM read data plus sop/eop
//                tags; head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_rd_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_wr_en,
    input  wire logic [WIDTH-1:0]           i_wr_data,
    input  wire logic                       i_rd_en,
    output logic      [WIDTH-1:0]           o_rd_data,
    output logic      [$clog2(DEPTH+1)-1:0] o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    // Storage, wrapping pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pkt_reader.sv
// ============================================================================
//  Module      : pkt_reader
//  Description : Per-output-port packet read engine. Takes one descriptor
//                at a time, issues sequential SRAM reads under buffer
//                credit, and streams the packet out with sop/eop and
//                downstream backpressure; pulses done on the last beat.
//                Optional macro PKT_READER_LEN_CHK_EN: zero-length
//                descriptors are rejected with a len_err pulse instead of
//                meaning 2^LEN_WIDTH words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_reader import sw_pkg::*; #(
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int ADDR_WIDTH = SW_ADDR_WIDTH,
    parameter int LEN_WIDTH  = SW_LEN_WIDTH,
    parameter int PRIO_WIDTH = SW_PRIO_WIDTH,
    parameter int SRAM_LAT   = 2,
    parameter int BUF_DEPTH  = 4   // must be at least SRAM_LAT+2 for full rate
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    pkt_reader_if.master bus
);

    localparam int CNT_W     = LEN_WIDTH + 1;
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int LAT_CNT_W = $clog2(SRAM_LAT + 1);

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_issue_cnt;
    logic [PRIO_WIDTH-1:0] r_prio;
    logic [SRAM_LAT-1:0]   r_infl_vld;
    logic [SRAM_LAT-1:0]   r_infl_sop;
    logic [SRAM_LAT-1:0]   r_infl_eop;
    logic [LAT_CNT_W-1:0]  r_infl_cnt;

    logic                  w_desc_rdy;
    logic                  w_desc_hs;
    logic                  w_len_zero;
    logic [CNT_W-1:0]      w_len_ext;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_buf_wr;
    logic                  w_buf_full;
    logic                  w_buf_empty;
    logic [BUF_CNT_W-1:0]  w_buf_cnt;
    logic [DATA_WIDTH+1:0] w_buf_wdata;
    logic [DATA_WIDTH+1:0] w_buf_rdata;
    logic                  w_pop;
    logic                  w_head_sop;
    logic                  w_head_eop;
    logic                  w_done;

    // A zero length field encodes the largest packet, 2^LEN_WIDTH words
    assign w_len_zero = (bus.desc_len == '0);
    assign w_len_ext  = w_len_zero ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, bus.desc_len};
    assign w_desc_hs  = bus.desc_vld && w_desc_rdy;

    // Reads in flight plus buffered words may never exceed the buffer;
    // a pop in the same cycle is deliberately not credited.
    assign w_credit = (int'(r_infl_cnt) + int'(w_buf_cnt)) < BUF_DEPTH;

    // Data returns from the SRAM exactly when the shadow pipeline's tap is set
    assign w_buf_wr    = r_infl_vld[SRAM_LAT-1];
    assign w_buf_wdata = {r_infl_eop[SRAM_LAT-1], r_infl_sop[SRAM_LAT-1], bus.doutb};

    assign w_head_sop = w_buf_rdata[DATA_WIDTH];
    assign w_head_eop = w_buf_rdata[DATA_WIDTH+1];
    assign w_pop      = !w_buf_empty && bus.out_ready;
    assign w_done     = w_pop && w_head_eop;

    // Next-state and issue decode
    always_comb begin
        w_state_nxt = r_state;
        w_desc_rdy  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            RD_IDLE: begin
                w_desc_rdy = 1'b1;
                if (bus.desc_vld) begin
`ifdef PKT_READER_LEN_CHK_EN
                    if (!w_len_zero) begin
                        w_state_nxt = RD_FETCH;
                    end
`else
                    w_state_nxt = RD_FETCH;
`endif
                end
            end
            RD_FETCH: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_issue_cnt == r_len - CNT_W'(1)) begin
                        w_state_nxt = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (w_done) begin
                    w_state_nxt = RD_IDLE;
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Descriptor latch and read issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_prio      <= '0;
            r_issue_cnt <= '0;
        end else if (w_desc_hs) begin
            r_addr      <= bus.desc_addr;
            r_len       <= w_len_ext;
            r_prio      <= bus.desc_prio;
            r_issue_cnt <= '0;
        end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
    end

    // Shadow of the SRAM read pipeline: valid and packet tags per read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infl_vld <= '0;
            r_infl_sop <= '0;
            r_infl_eop <= '0;
            r_infl_cnt <= '0;
        end else begin
            r_infl_vld[0] <= w_issue;
            r_infl_sop[0] <= w_issue && (r_issue_cnt == '0);
            r_infl_eop[0] <= w_issue && (r_issue_cnt == r_len - CNT_W'(1));
            for (int i = 1; i < SRAM_LAT; i++) begin
                r_infl_vld[i] <= r_infl_vld[i-1];
                r_infl_sop[i] <= r_infl_sop[i-1];
                r_infl_eop[i] <= r_infl_eop[i-1];
            end
            case ({w_issue, w_buf_wr})
                2'b10:   r_infl_cnt <= r_infl_cnt + LAT_CNT_W'(1);
                2'b01:   r_infl_cnt <= r_infl_cnt - LAT_CNT_W'(1);
                default: r_infl_cnt <= r_infl_cnt;
            endcase
        end
    end

    pkt_rd_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH + 2)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_buf_wr),
        .i_wr_data (w_buf_wdata),
        .i_rd_en   (w_pop),
        .o_rd_data (w_buf_rdata),
        .o_count   (w_buf_cnt),
        .o_full    (w_buf_full),
        .o_empty   (w_buf_empty)
    );

    assign bus.desc_rdy  = w_desc_rdy;
    assign bus.enb       = w_issue;
    assign bus.addrb     = w_issue ? (r_addr + ADDR_WIDTH'(r_issue_cnt)) : '0;
    assign bus.rd_vld    = !w_buf_empty;
    assign bus.rd_data   = w_buf_empty ? '0 : w_buf_rdata[DATA_WIDTH-1:0];
    assign bus.rd_sop    = !w_buf_empty && w_head_sop;
    assign bus.rd_eop    = !w_buf_empty && w_head_eop;
    assign bus.done      = w_done;
    assign bus.done_prio = w_done ? r_prio : '0;
    assign bus.busy      = (r_state != RD_IDLE);

`ifdef PKT_READER_LEN_CHK_EN
    logic r_len_err;

    // One-cycle flag for a rejected zero-length descriptor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_desc_hs && w_len_zero;
        end
    end

    assign bus.len_err = r_len_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_reader.sv
// ============================================================================
//  Module      : tb_pkt_reader
//  Description : Self-checking bench for pkt_reader with an SRAM model
//                (mem[a] = a) and a reference expectation built from the
//                descriptor. Honours PKT_READER_LEN_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_reader;
    import sw_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 17;
    localparam int DW    = 64;
    localparam int LW    = 8;
    localparam int PW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;
    int   ovf_cnt = 0;

    pkt_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .PRIO_WIDTH(PW)) bus ();

    pkt_reader #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .LEN_WIDTH (LW), .PRIO_WIDTH (PW),
        .SRAM_LAT (LAT), .BUF_DEPTH (DEPTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: mem[a] = a, data appears LAT cycles after enb
    logic [DW-1:0] sram_pipe [LAT];
    always @(posedge clk) begin
        sram_pipe[0] <= bus.enb ? DW'(bus.addrb) : 64'hDEAD_BEEF_0BAD_F00D;
        for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign bus.doutb = sram_pipe[LAT-1];

    // Buffer write while full would lose data
    always @(negedge clk) begin
        if (rst_n && u_dut.w_buf_wr && u_dut.w_buf_full) ovf_cnt++;
    end

    // Observations of one collection window
    logic [DW-1:0] ob_data [$];
    bit            ob_sop [$];
    bit            ob_eop [$];
    int            ob_cyc [$];
    int            en_cyc [$];
    logic [AW-1:0] en_addr [$];
    int            done_cnt, done_cyc, done_beat, stall_viol, lenerr_cnt, lenerr_cyc;
    logic [PW-1:0] done_pr;
    bit            busy_c1;

    function automatic logic [DW-1:0] exp_word(logic [AW-1:0] base, int i);
        return DW'((int'(base) + i) % (1 << AW));
    endfunction

    task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] n, input logic [PW-1:0] p);
        bus.desc_vld  = 1'b1;
        bus.desc_addr = a;
        bus.desc_len  = n;
        bus.desc_prio = p;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.desc_vld = 1'b0;
    endtask

    // Runs cycle by cycle from T+1, recording everything the DUT emits
    task automatic collect(input int budget, input int mode, input bit stop_on_done, input int max_beats);
        logic [DW-1:0] st_data;
        bit st_sop, st_eop, st_valid;
        ob_data.delete(); ob_sop.delete(); ob_eop.delete(); ob_cyc.delete();
        en_cyc.delete(); en_addr.delete();
        done_cnt = 0; done_cyc = -1; done_beat = -1; done_pr = '0;
        stall_viol = 0; lenerr_cnt = 0; lenerr_cyc = -1; busy_c1 = 1'b0;
        st_valid = 1'b0; st_data = '0; st_sop = 1'b0; st_eop = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (k % 2) == 1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (k == 1) busy_c1 = bus.busy;
            if (bus.enb) begin
                en_cyc.push_back(k);
                en_addr.push_back(bus.addrb);
            end
            if (st_valid && (!bus.rd_vld || {bus.rd_data, bus.rd_sop, bus.rd_eop} != {st_data, st_sop, st_eop}))
                stall_viol++;
            st_valid = bus.rd_vld && !bus.out_ready;
            st_data = bus.rd_data; st_sop = bus.rd_sop; st_eop = bus.rd_eop;
            if (bus.rd_vld && bus.out_ready) begin
                ob_data.push_back(bus.rd_data);
                ob_sop.push_back(bus.rd_sop);
                ob_eop.push_back(bus.rd_eop);
                ob_cyc.push_back(k);
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = k;
                done_pr = bus.done_prio;
                done_beat = ob_data.size();
            end
`ifdef PKT_READER_LEN_CHK_EN
            if (bus.len_err) begin
                lenerr_cnt++;
                lenerr_cyc = k;
            end
`endif
            @(posedge clk);
            #1;
            if (stop_on_done && done_cnt > 0) break;
            if (max_beats > 0 && ob_data.size() >= max_beats) break;
        end
    endtask

    task automatic test_reset();
        bus.desc_vld = 1'b0; bus.desc_addr = '0; bus.desc_len = '0; bus.desc_prio = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int ph = 0; ph < 2; ph++) begin
            n_checks++;
            if ({bus.desc_rdy, bus.enb, bus.rd_vld, bus.rd_sop, bus.rd_eop, bus.done, bus.busy} !== 7'b1000000) begin
                n_errs++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 1000000", ph,
                         {bus.desc_rdy, bus.enb, bus.rd_vld, bus.rd_sop, bus.rd_eop, bus.done, bus.busy});
            end
            n_checks++;
            if ({bus.addrb, bus.rd_data, bus.done_prio} !== '0) begin
                n_errs++;
                $display("FAIL reset_bus[%0d]: addrb=%h rd_data=%h done_prio=%h expected all zero", ph,
                         bus.addrb, bus.rd_data, bus.done_prio);
            end
`ifdef PKT_READER_LEN_CHK_EN
            n_checks++;
            if (bus.len_err !== 1'b0) begin
                n_errs++;
                $display("FAIL reset_len_err[%0d]: got %b expected 0", ph, bus.len_err);
            end
`endif
            if (ph == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_basic();
        send_desc(17'h00100, 8'd4, 3'd5);
        collect(40, 0, 1'b1, 0);
        n_checks++;
        if (busy_c1 !== 1'b1) begin
            n_errs++; $display("FAIL basic_busy: got %b expected 1", busy_c1);
        end
        n_checks++;
        if (en_cyc.size() != 4) begin
            n_errs++; $display("FAIL basic_enb_count: got %0d expected 4", en_cyc.size());
        end
        for (int i = 0; i < 4 && i < en_cyc.size(); i++) begin
            n_checks++;
            if (en_cyc[i] != i + 1 || en_addr[i] !== AW'(17'h100 + i)) begin
                n_errs++;
                $display("FAIL basic_enb[%0d]: cycle %0d addr %h expected cycle %0d addr %h",
                         i, en_cyc[i], en_addr[i], i + 1, 17'h100 + i);
            end
        end
        n_checks++;
        if (ob_data.size() != 4) begin
            n_errs++; $display("FAIL basic_beats: got %0d expected 4", ob_data.size());
        end
        for (int i = 0; i < 4 && i < ob_data.size(); i++) begin
            n_checks++;
            if (ob_cyc[i] != i + 4 || ob_data[i] !== exp_word(17'h100, i) ||
                ob_sop[i] != (i == 0) || ob_eop[i] != (i == 3)) begin
                n_errs++;
                $display("FAIL basic_beat[%0d]: cyc %0d data %h sop %b eop %b expected cyc %0d data %h sop %b eop %b",
                         i, ob_cyc[i], ob_data[i], ob_sop[i], ob_eop[i], i + 4, exp_word(17'h100, i), i == 0, i == 3);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 7 || done_pr !== 3'd5) begin
            n_errs++;
            $display("FAIL basic_done: count %0d cycle %0d prio %0d expected 1, 7, 5", done_cnt, done_cyc, done_pr);
        end
        n_checks++;
        if (bus.desc_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            n_errs++;
            $display("FAIL basic_after_done: desc_rdy %b busy %b expected 1 0", bus.desc_rdy, bus.busy);
        end
    endtask

    task automatic test_len1();
        logic [AW-1:0] a;
        a = AW'($urandom);
        send_desc(a, 8'd1, 3'd2);
        collect(30, 0, 1'b1, 0);
        n_checks++;
        if (ob_data.size() != 1) begin
            n_errs++; $display("FAIL len1_beats: got %0d expected 1", ob_data.size());
        end else begin
            n_checks++;
            if (ob_data[0] !== exp_word(a, 0) || !ob_sop[0] || !ob_eop[0] || ob_cyc[0] != 4) begin
                n_errs++;
                $display("FAIL len1_beat: data %h sop %b eop %b cyc %0d expected %h 1 1 4",
                         ob_data[0], ob_sop[0], ob_eop[0], ob_cyc[0], exp_word(a, 0));
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 4 || done_pr !== 3'd2) begin
            n_errs++;
            $display("FAIL len1_done: count %0d cycle %0d prio %0d expected 1, 4, 2", done_cnt, done_cyc, done_pr);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
        send_desc(17'h1FFFE, 8'd4, 3'd0);
        collect(40, 0, 1'b1, 0);
        n_checks++;
        if (en_addr.size() != 4) begin
            n_errs++; $display("FAIL wrap_count: got %0d expected 4", en_addr.size());
        end
        for (int i = 0; i < 4 && i < en_addr.size(); i++) begin
            n_checks++;
            if (en_addr[i] !== exp_a[i] || ob_data.size() != 4 || ob_data[i] !== DW'(exp_a[i])) begin
                n_errs++;
                $display("FAIL wrap_addr[%0d]: addrb %h expected %h", i, en_addr[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        a = AW'($urandom);
        send_desc(a, 8'd16, 3'd6);
        collect(200, 1, 1'b1, 0);
        n_checks++;
        if (ob_data.size() != 16) begin
            n_errs++; $display("FAIL bp_beats: got %0d expected 16", ob_data.size());
        end
        for (int i = 0; i < 16 && i < ob_data.size(); i++) begin
            n_checks++;
            if (ob_data[i] !== exp_word(a, i) || ob_sop[i] != (i == 0) || ob_eop[i] != (i == 15)) begin
                n_errs++;
                $display("FAIL bp_beat[%0d]: data %h sop %b eop %b expected %h %b %b",
                         i, ob_data[i], ob_sop[i], ob_eop[i], exp_word(a, i), i == 0, i == 15);
            end
        end
        n_checks++;
        if (stall_viol != 0 || done_cnt != 1 || done_beat != 16) begin
            n_errs++;
            $display("FAIL bp_stall: unstable %0d done %0d on beat %0d expected 0, 1, 16", stall_viol, done_cnt, done_beat);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        a = AW'($urandom);
        send_desc(a, 8'd8, 3'd1);
        collect(40, 0, 1'b1, 0);
        n_checks++;
        if (ob_data.size() != 8) begin
            n_errs++; $display("FAIL b2b_beats: got %0d expected 8", ob_data.size());
        end
        for (int i = 0; i < 8 && i < ob_data.size(); i++) begin
            n_checks++;
            if (ob_cyc[i] != i + 4 || ob_data[i] !== exp_word(a, i)) begin
                n_errs++;
                $display("FAIL b2b_beat[%0d]: cyc %0d data %h expected cyc %0d data %h",
                         i, ob_cyc[i], ob_data[i], i + 4, exp_word(a, i));
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [PW-1:0] p;
        int n, bad;
        for (int pk = 0; pk < 6; pk++) begin
            a = AW'($urandom);
            n = $urandom_range(1, 24);
            p = PW'($urandom);
            send_desc(a, LW'(n), p);
            collect(2000, 2, 1'b1, 0);
            n_checks++;
            if (ob_data.size() != n || done_cnt != 1 || done_beat != n || done_pr !== p) begin
                n_errs++;
                $display("FAIL rand_pkt[%0d]: beats %0d done %0d@beat %0d prio %0d expected %0d beats, done@%0d prio %0d",
                         pk, ob_data.size(), done_cnt, done_beat, done_pr, n, n, p);
            end
            bad = 0;
            for (int i = 0; i < n && i < ob_data.size(); i++) begin
                if (ob_data[i] !== exp_word(a, i) || ob_sop[i] != (i == 0) || ob_eop[i] != (i == n - 1)) bad++;
            end
            n_checks++;
            if (bad != 0 || stall_viol != 0) begin
                n_errs++;
                $display("FAIL rand_data[%0d]: wrong beats %0d unstable stalls %0d expected 0 0", pk, bad, stall_viol);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        send_desc(AW'($urandom), 8'd8, 3'd4);
        collect(40, 0, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.desc_rdy, bus.enb, bus.rd_vld, bus.rd_sop, bus.rd_eop, bus.done, bus.busy} !== 7'b1000000 ||
            {bus.addrb, bus.rd_data, bus.done_prio} !== '0) begin
            n_errs++;
            $display("FAIL rstmid_outputs: ctrl %b data %h addrb %h expected ctrl 1000000 and zeros",
                     {bus.desc_rdy, bus.enb, bus.rd_vld, bus.rd_sop, bus.rd_eop, bus.done, bus.busy},
                     bus.rd_data, bus.addrb);
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_errs++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a = AW'($urandom);
        send_desc(a, 8'd2, 3'd3);
        collect(30, 0, 1'b0, 0);
        n_checks++;
        if (ob_data.size() != 2 || en_cyc.size() != 2 || done_cnt != 1) begin
            n_errs++;
            $display("FAIL rstmid_len2: beats %0d reads %0d done %0d expected 2 2 1",
                     ob_data.size(), en_cyc.size(), done_cnt);
        end
        for (int i = 0; i < 2 && i < ob_data.size(); i++) begin
            n_checks++;
            if (ob_data[i] !== exp_word(a, i) || ob_sop[i] != (i == 0) || ob_eop[i] != (i == 1)) begin
                n_errs++;
                $display("FAIL rstmid_beat[%0d]: data %h sop %b eop %b expected %h %b %b",
                         i, ob_data[i], ob_sop[i], ob_eop[i], exp_word(a, i), i == 0, i == 1);
            end
        end
    endtask

    task automatic test_len0();
        logic [AW-1:0] a;
        int bad;
        a = AW'($urandom);
        send_desc(a, 8'd0, 3'd7);
`ifdef PKT_READER_LEN_CHK_EN
        collect(20, 0, 1'b0, 0);
        n_checks++;
        if (lenerr_cnt != 1 || lenerr_cyc != 1) begin
            n_errs++; $display("FAIL len0_err: count %0d cycle %0d expected 1 1", lenerr_cnt, lenerr_cyc);
        end
        n_checks++;
        if (en_cyc.size() != 0 || done_cnt != 0 || ob_data.size() != 0 || busy_c1 !== 1'b0) begin
            n_errs++;
            $display("FAIL len0_quiet: reads %0d done %0d beats %0d busy %b expected 0 0 0 0",
                     en_cyc.size(), done_cnt, ob_data.size(), busy_c1);
        end
`else
        collect(400, 0, 1'b1, 0);
        n_checks++;
        if (ob_data.size() != 256 || done_cnt != 1 || done_beat != 256 || done_pr !== 3'd7) begin
            n_errs++;
            $display("FAIL len0_full: beats %0d done %0d@beat %0d prio %0d expected 256, 1@256, 7",
                     ob_data.size(), done_cnt, done_beat, done_pr);
        end
        bad = 0;
        for (int i = 0; i < 256 && i < ob_data.size(); i++) begin
            if (ob_data[i] !== exp_word(a, i) || ob_sop[i] != (i == 0) || ob_eop[i] != (i == 255)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errs++; $display("FAIL len0_data: wrong beats %0d expected 0", bad);
        end
`endif
    endtask

    initial begin
        bus.desc_vld = 1'b0;
        bus.desc_addr = '0;
        bus.desc_len = '0;
        bus.desc_prio = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len1();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_len0();
        n_checks++;
        if (ovf_cnt != 0) begin
            n_errs++; $display("FAIL buf_overflow: writes while full %0d expected 0", ovf_cnt);
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
